// File: rtl/wb_writer_pkg.sv
// Shared configuration for the write-back front end.
// Supplies register-file geometry, reset/write polarities, the default
// port-B FIFO depth, the result-source select encoding and the FIFO entry type.
package wb_writer_pkg;

  localparam int unsigned RegLen     = 32;
  localparam int unsigned RegAddrLen = 5;
  localparam int unsigned RegNum     = 32;

  localparam logic [RegLen-1:0] ZERO_WORD   = '0;
  localparam logic              ResetEnable = 1'b1;
  localparam logic              WriteEnable = 1'b1;

  localparam int unsigned WB_FIFO_DEPTH = 4;

  typedef enum logic {
    WB_SRC_A = 1'b0,
    WB_SRC_B = 1'b1
  } wb_src_e;

  typedef struct packed {
    logic [RegAddrLen-1:0] addr;
    logic [RegLen-1:0]     data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO buffering late load returns (port B) for the write-back stage.
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   push_i, wdata_i write an entry at the tail (ignored when full)
//   pop_i, rdata_o  remove the head entry (ignored when empty); rdata_o shows the head
//   full_o, empty_o occupancy flags
//   count_o         current occupancy, 0..DEPTH
module wb_fifo
  import wb_writer_pkg::*;
#(
  parameter int unsigned DEPTH = WB_FIFO_DEPTH,
  parameter int unsigned PTR_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  wb_entry_t        wdata_i,
  input  logic             pop_i,
  output wb_entry_t        rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [PTR_W:0]   count_o
);

  localparam logic [PTR_W:0] FullCnt = (PTR_W + 1)'(DEPTH);

  wb_entry_t          mem_q [DEPTH];
  logic [PTR_W-1:0]   head_q, head_d;
  logic [PTR_W-1:0]   tail_q, tail_d;
  logic [PTR_W:0]     count_q, count_d;
  logic               do_push, do_pop;

  assign full_o  = (count_q == FullCnt);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[head_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Pointers are PTR_W wide so they wrap modulo DEPTH for free.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (do_push) tail_d = tail_q + 1'b1;
    if (do_pop)  head_d = head_q + 1'b1;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst == ResetEnable) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage is not reset; clearing the pointers discards its contents.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[tail_q] <= wdata_i;
  end

endmodule

// File: rtl/wb_writer.sv
// Write-back front end: sole driver of the register file write port.
// Port A (pipeline retire) has strict priority and is never stalled; port B
// (late load returns) is buffered in wb_fifo and drained when A is idle.
// A pending-load scoreboard tells ID which registers await a load return.
// Ports:
//   clk, rst                       clock and synchronous active-high reset
//   a_valid, a_addr, a_data        retire result (always accepted)
//   b_valid, b_ready, b_addr,
//   b_data                         load return handshake
//   issue_valid, issue_rd          load issued to memory; marks issue_rd pending
//   write_enable, write_addr,
//   write_data                     registered register-file write port
//   pending                        bit i: register i awaits a load return
//   fifo_count                     current port-B FIFO occupancy
module wb_writer
  import wb_writer_pkg::*;
#(
  parameter int unsigned DEPTH = WB_FIFO_DEPTH,
  parameter int unsigned PTR_W = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  a_valid,
  input  logic [RegAddrLen-1:0] a_addr,
  input  logic [RegLen-1:0]     a_data,
  input  logic                  b_valid,
  output logic                  b_ready,
  input  logic [RegAddrLen-1:0] b_addr,
  input  logic [RegLen-1:0]     b_data,
  input  logic                  issue_valid,
  input  logic [RegAddrLen-1:0] issue_rd,
  output logic                  write_enable,
  output logic [RegAddrLen-1:0] write_addr,
  output logic [RegLen-1:0]     write_data,
  output logic [RegNum-1:0]     pending,
  output logic [PTR_W:0]        fifo_count
);

  wb_entry_t   push_entry, head_entry;
  logic        fifo_full, fifo_empty;
  logic        push, pop;
  logic        sel_valid;
  wb_src_e     sel_src;

  logic                  we_q, we_d;
  logic [RegAddrLen-1:0] addr_q, addr_d;
  logic [RegLen-1:0]     data_q, data_d;
  logic [RegNum-1:0]     pending_q, pending_d;

  // Ready depends only on the registered count: no bypass into a full FIFO.
  assign b_ready    = !fifo_full;
  assign push       = b_valid && b_ready;
  assign push_entry = '{addr: b_addr, data: b_data};

  wb_fifo #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .wdata_i (push_entry),
    .pop_i   (pop),
    .rdata_o (head_entry),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Strict A priority; B drains only on cycles with no retire result.
  always_comb begin
    sel_valid = 1'b0;
    sel_src   = WB_SRC_A;
    pop       = 1'b0;
    if (a_valid) begin
      sel_valid = 1'b1;
      sel_src   = WB_SRC_A;
    end else if (!fifo_empty) begin
      sel_valid = 1'b1;
      sel_src   = WB_SRC_B;
      pop       = 1'b1;
    end
  end

  always_comb begin
    we_d   = 1'b0;
    addr_d = addr_q;
    data_d = data_q;
    if (sel_valid) begin
      unique case (sel_src)
        WB_SRC_A: begin
          addr_d = a_addr;
          data_d = a_data;
        end
        WB_SRC_B: begin
          addr_d = head_entry.addr;
          data_d = head_entry.data;
        end
        default: ;
      endcase
      // x0 is hardwired: the slot is consumed but no write is strobed.
      we_d = (addr_d != '0) ? WriteEnable : ~WriteEnable;
    end
  end

  // Set after clear so a same-cycle issue to the popped register wins.
  always_comb begin
    pending_d = pending_q;
    if (pop) pending_d[head_entry.addr] = 1'b0;
    if (issue_valid && (issue_rd != '0)) pending_d[issue_rd] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst == ResetEnable) begin
      we_q      <= 1'b0;
      addr_q    <= '0;
      data_q    <= ZERO_WORD;
      pending_q <= '0;
    end else begin
      we_q      <= we_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      pending_q <= pending_d;
    end
  end

  assign write_enable = we_q;
  assign write_addr   = addr_q;
  assign write_data   = data_q;
  assign pending      = pending_q;

endmodule

// File: tb/tb_wb_writer.sv
module tb_wb_writer;
  import wb_writer_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned PTR_W = 2;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  a_valid;
  logic [RegAddrLen-1:0] a_addr;
  logic [RegLen-1:0]     a_data;
  logic                  b_valid;
  logic                  b_ready;
  logic [RegAddrLen-1:0] b_addr;
  logic [RegLen-1:0]     b_data;
  logic                  issue_valid;
  logic [RegAddrLen-1:0] issue_rd;
  logic                  write_enable;
  logic [RegAddrLen-1:0] write_addr;
  logic [RegLen-1:0]     write_data;
  logic [RegNum-1:0]     pending;
  logic [PTR_W:0]        fifo_count;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic [RegAddrLen-1:0] addr;
    logic [RegLen-1:0]     data;
  } ent_t;

  wb_writer #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .a_valid      (a_valid),
    .a_addr       (a_addr),
    .a_data       (a_data),
    .b_valid      (b_valid),
    .b_ready      (b_ready),
    .b_addr       (b_addr),
    .b_data       (b_data),
    .issue_valid  (issue_valid),
    .issue_rd     (issue_rd),
    .write_enable (write_enable),
    .write_addr   (write_addr),
    .write_data   (write_data),
    .pending      (pending),
    .fifo_count   (fifo_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    a_valid     = 1'b0;
    a_addr      = '0;
    a_data      = '0;
    b_valid     = 1'b0;
    b_addr      = '0;
    b_data      = '0;
    issue_valid = 1'b0;
    issue_rd    = '0;
  endtask

  function automatic logic [RegAddrLen-1:0] entry_addr(int p);
    return (p == 6) ? 5'd0 : 5'(p + 1);
  endfunction

  function automatic logic [RegLen-1:0] entry_data(int p);
    return 32'hC0DE0000 + 32'(p * 17);
  endfunction

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      n_cmp++;
      if (write_enable !== 1'b0) begin
        n_fail++; $display("FAIL reset_we cyc%0d: got %b want 0", i, write_enable);
      end
      n_cmp++;
      if (b_ready !== 1'b1) begin
        n_fail++; $display("FAIL reset_b_ready cyc%0d: got %b want 1", i, b_ready);
      end
      n_cmp++;
      if (pending !== 32'h0) begin
        n_fail++; $display("FAIL reset_pending cyc%0d: got %h want 0", i, pending);
      end
      n_cmp++;
      if (fifo_count !== 3'd0) begin
        n_fail++; $display("FAIL reset_count cyc%0d: got %0d want 0", i, fifo_count);
      end
    end
  endtask

  task automatic test_a_only();
    a_valid = 1'b1; a_addr = 5'd5; a_data = 32'hDEADBEEF;
    step();
    a_valid = 1'b0;
    n_cmp++;
    if (write_enable !== 1'b1 || write_addr !== 5'd5 || write_data !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL a_write: got we=%b addr=%0d data=%h want 1/5/deadbeef",
               write_enable, write_addr, write_data);
    end
    step();
    n_cmp++;
    if (write_enable !== 1'b0 || write_addr !== 5'd5 || write_data !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL idle_hold: got we=%b addr=%0d data=%h want 0/5/deadbeef",
               write_enable, write_addr, write_data);
    end
    a_valid = 1'b1; a_addr = 5'd0; a_data = 32'h11111111;
    step();
    a_valid = 1'b0;
    n_cmp++;
    if (write_enable !== 1'b0) begin
      n_fail++; $display("FAIL a_x0: got we=%b want 0", write_enable);
    end
    n_cmp++;
    if (pending !== 32'h0) begin
      n_fail++; $display("FAIL a_pending: got %h want 0", pending);
    end
  endtask

  task automatic test_load_round_trip();
    issue_valid = 1'b1; issue_rd = 5'd0;
    step();
    n_cmp++;
    if (pending !== 32'h0) begin
      n_fail++; $display("FAIL issue_x0: got %h want 0", pending);
    end
    issue_rd = 5'd7;
    step();
    issue_valid = 1'b0;
    n_cmp++;
    if (pending !== 32'h0000_0080) begin
      n_fail++; $display("FAIL issue_set: got %h want 00000080", pending);
    end
    b_valid = 1'b1; b_addr = 5'd7; b_data = 32'h12345678;
    step();
    b_valid = 1'b0;
    n_cmp++;
    if (write_enable !== 1'b0 || fifo_count !== 3'd1 || pending !== 32'h0000_0080) begin
      n_fail++;
      $display("FAIL load_push: got we=%b cnt=%0d pend=%h want 0/1/00000080",
               write_enable, fifo_count, pending);
    end
    step();
    n_cmp++;
    if (write_enable !== 1'b1 || write_addr !== 5'd7 || write_data !== 32'h12345678) begin
      n_fail++;
      $display("FAIL load_write: got we=%b addr=%0d data=%h want 1/7/12345678",
               write_enable, write_addr, write_data);
    end
    n_cmp++;
    if (pending !== 32'h0 || fifo_count !== 3'd0) begin
      n_fail++;
      $display("FAIL load_clear: got pend=%h cnt=%0d want 0/0", pending, fifo_count);
    end
  endtask

  task automatic test_priority();
    logic [RegAddrLen-1:0] baddrs [3];
    logic [RegAddrLen-1:0] exp_addr;
    baddrs[0] = 5'd3; baddrs[1] = 5'd4; baddrs[2] = 5'd9;
    for (int i = 0; i < 6; i++) begin
      a_valid = 1'b1; a_addr = 5'(10 + i); a_data = 32'hAAAA0000 + 32'(i);
      b_valid = (i < 3);
      b_addr  = (i < 3) ? baddrs[i] : 5'd0;
      b_data  = (i < 3) ? 32'hB0B00000 + 32'(baddrs[i]) : 32'h0;
      step();
      n_cmp++;
      if (write_enable !== 1'b1 || write_addr !== 5'(10 + i)
          || write_data !== 32'hAAAA0000 + 32'(i)) begin
        n_fail++;
        $display("FAIL prio_a cyc%0d: got we=%b addr=%0d data=%h want 1/%0d/%h", i,
                 write_enable, write_addr, write_data, 10 + i, 32'hAAAA0000 + 32'(i));
      end
      n_cmp++;
      if (fifo_count !== 3'((i < 3) ? i + 1 : 3)) begin
        n_fail++;
        $display("FAIL prio_count cyc%0d: got %0d want %0d", i, fifo_count,
                 (i < 3) ? i + 1 : 3);
      end
    end
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      step();
      exp_addr = baddrs[i];
      n_cmp++;
      if (write_enable !== 1'b1 || write_addr !== exp_addr
          || write_data !== 32'hB0B00000 + 32'(exp_addr)) begin
        n_fail++;
        $display("FAIL drain%0d: got we=%b addr=%0d data=%h want 1/%0d/%h", i,
                 write_enable, write_addr, write_data, exp_addr,
                 32'hB0B00000 + 32'(exp_addr));
      end
      n_cmp++;
      if (fifo_count !== 3'(2 - i)) begin
        n_fail++; $display("FAIL drain_count%0d: got %0d want %0d", i, fifo_count, 2 - i);
      end
    end
    step();
    n_cmp++;
    if (write_enable !== 1'b0) begin
      n_fail++; $display("FAIL drain_idle: got we=%b want 0", write_enable);
    end
  endtask

  task automatic test_full_wrap();
    ent_t q[$];
    ent_t e;
    int   p = 0;
    int   cyc = 0;
    bit   aon, popped, acc;
    while ((p < 12 || q.size() != 0) && cyc < 60) begin
      aon     = (cyc < 6);
      a_valid = aon; a_addr = 5'd20; a_data = 32'h0A0A0000 + 32'(cyc);
      b_valid = (p < 12); b_addr = entry_addr(p); b_data = entry_data(p);
      n_cmp++;
      if (b_ready !== (q.size() != DEPTH)) begin
        n_fail++;
        $display("FAIL wrap_ready cyc%0d: got %b want %b", cyc, b_ready, q.size() != DEPTH);
      end
      acc    = (p < 12) && (q.size() != DEPTH);
      popped = 1'b0;
      if (!aon && q.size() > 0) begin
        e      = q.pop_front();
        popped = 1'b1;
      end
      if (acc) begin
        q.push_back('{addr: b_addr, data: b_data});
        p++;
      end
      step();
      if (aon) begin
        n_cmp++;
        if (write_enable !== 1'b1 || write_addr !== 5'd20) begin
          n_fail++;
          $display("FAIL wrap_a cyc%0d: got we=%b addr=%0d want 1/20", cyc, write_enable,
                   write_addr);
        end
      end else if (popped) begin
        n_cmp++;
        if (write_enable !== (e.addr != 5'd0) || write_addr !== e.addr
            || write_data !== e.data) begin
          n_fail++;
          $display("FAIL wrap_b cyc%0d: got we=%b addr=%0d data=%h want %b/%0d/%h", cyc,
                   write_enable, write_addr, write_data, e.addr != 5'd0, e.addr, e.data);
        end
      end else begin
        n_cmp++;
        if (write_enable !== 1'b0) begin
          n_fail++; $display("FAIL wrap_idle cyc%0d: got we=%b want 0", cyc, write_enable);
        end
      end
      n_cmp++;
      if (fifo_count !== 3'(q.size())) begin
        n_fail++;
        $display("FAIL wrap_count cyc%0d: got %0d want %0d", cyc, fifo_count, q.size());
      end
      cyc++;
    end
    n_cmp++;
    if (cyc >= 60) begin
      n_fail++; $display("FAIL wrap_timeout: got %0d cycles want <60", cyc);
    end
    idle_inputs();
  endtask

  task automatic test_same_cycle();
    issue_valid = 1'b1; issue_rd = 5'd7;
    step();
    issue_valid = 1'b0;
    b_valid = 1'b1; b_addr = 5'd7; b_data = 32'h00000077;
    step();
    b_valid = 1'b0;
    issue_valid = 1'b1; issue_rd = 5'd7;
    step();
    issue_valid = 1'b0;
    n_cmp++;
    if (write_enable !== 1'b1 || write_addr !== 5'd7 || write_data !== 32'h00000077) begin
      n_fail++;
      $display("FAIL same_write: got we=%b addr=%0d data=%h want 1/7/00000077",
               write_enable, write_addr, write_data);
    end
    n_cmp++;
    if (pending !== 32'h0000_0080) begin
      n_fail++; $display("FAIL same_set_wins: got %h want 00000080", pending);
    end
    a_valid = 1'b1; a_addr = 5'd7; a_data = 32'h00000707;
    step();
    a_valid = 1'b0;
    n_cmp++;
    if (write_enable !== 1'b1 || pending !== 32'h0000_0080) begin
      n_fail++;
      $display("FAIL a_keeps_pending: got we=%b pend=%h want 1/00000080", write_enable,
               pending);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      a_valid = 1'b1; a_addr = 5'd1; a_data = 32'h1;
      b_valid = 1'b1; b_addr = 5'(12 + i); b_data = 32'h5EED0000 + 32'(i);
      step();
    end
    idle_inputs();
    n_cmp++;
    if (fifo_count !== 3'd3) begin
      n_fail++; $display("FAIL pre_reset_count: got %0d want 3", fifo_count);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_cmp++;
    if (write_enable !== 1'b0 || write_addr !== 5'd0 || write_data !== 32'h0) begin
      n_fail++;
      $display("FAIL mid_reset_out: got we=%b addr=%0d data=%h want 0/0/0", write_enable,
               write_addr, write_data);
    end
    n_cmp++;
    if (pending !== 32'h0 || fifo_count !== 3'd0 || b_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_reset_state: got pend=%h cnt=%0d rdy=%b want 0/0/1", pending,
               fifo_count, b_ready);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++;
      if (write_enable !== 1'b0 || fifo_count !== 3'd0) begin
        n_fail++;
        $display("FAIL stale_write cyc%0d: got we=%b cnt=%0d want 0/0", i, write_enable,
                 fifo_count);
      end
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_a_only();
    test_load_round_trip();
    test_priority();
    test_full_wrap();
    test_same_cycle();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
